// File: rtl/data_bus_if.sv
// Data-memory to Wishbone B4 classic bridge: turns a single-cycle core RAM access
// into one bus cycle, stalls the pipeline meanwhile and aborts on an ack timeout.
module data_bus_if #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        err_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o
);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BUSY           = 2'd1,
        WAIT_FOR_STALL = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rd_buf_q, rd_buf_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic              stb_q, stb_d;
    logic              cyc_q, cyc_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout;

    // An ack in the same cycle as the last allowed wait state wins over the abort.
    assign timeout = (TIMEOUT_CYCLES != 0) && (state_q == BUSY) && !wb_ack_i &&
                     (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_buf_d   = rd_buf_q;
        we_d       = we_q;
        sel_d      = sel_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;

        case (state_q)
            IDLE: begin
                if (cpu_ce_i) begin
                    stallreq_o = 1'b1;
                    addr_d     = cpu_addr_i;
                    wdata_d    = cpu_data_i;
                    we_d       = cpu_we_i;
                    sel_d      = cpu_sel_i;
                    stb_d      = 1'b1;
                    cyc_d      = 1'b1;
                    cnt_d      = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (wb_ack_i || timeout) begin
                    addr_d  = 32'h0;
                    wdata_d = 32'h0;
                    we_d    = 1'b0;
                    sel_d   = 4'b0000;
                    stb_d   = 1'b0;
                    cyc_d   = 1'b0;
                    if (wb_ack_i && !we_q) begin
                        cpu_data_o = wb_data_i;
                        rd_buf_d   = wb_data_i;
                    end else begin
                        rd_buf_d   = 32'h0;
                    end
                    err_d   = timeout;
                    state_d = (stall_i != 6'd0) ? WAIT_FOR_STALL : IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            WAIT_FOR_STALL: begin
                // Hold load data until the other stall source lets the pipeline move.
                cpu_data_o = rd_buf_q;
                if (stall_i == 6'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rd_buf_q <= 32'h0;
            we_q     <= 1'b0;
            sel_q    <= 4'b0000;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_buf_q <= rd_buf_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_stb_o  = stb_q;
    assign wb_cyc_o  = cyc_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_data_bus_if.sv
// Bench for data_bus_if: directed and random transactions against a per-transaction
// model of stall, bus and read-data behaviour.
module tb_data_bus_if;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        err_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   ncyc     = 0;
    int   exp_ncyc = 0;
    logic cyc_prev = 1'b0;
    logic pend_err = 1'b0;

    always #5 clk = ~clk;

    data_bus_if #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .err_o      (err_o),
        .wb_data_i  (wb_data_i),
        .wb_ack_i   (wb_ack_i),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o)
    );

    // Count Wishbone cycles as rising edges of cyc.
    always @(negedge clk) begin
        if (wb_cyc_o && !cyc_prev) ncyc++;
        cyc_prev = wb_cyc_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // In any non-BUSY cycle the bus must be fully released.
    task automatic bus_released(input string pfx);
        chk({pfx, "_ctl"}, {26'h0, wb_cyc_o, wb_stb_o, wb_we_o, |wb_sel_o, 2'b00}, 32'h0);
        chk({pfx, "_addr"}, wb_addr_o, 32'h0);
        chk({pfx, "_wdata"}, wb_data_o, 32'h0);
        chk({pfx, "_err"}, {31'h0, err_o}, {31'h0, pend_err});
        pend_err = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cpu_ce_i  = 1'b0;
        stall_i   = 6'd0;
        wb_ack_i  = 1'($urandom_range(0, 1));
        wb_data_i = $urandom;
        #1;
        chk("idle_stallreq", {31'h0, stallreq_o}, 32'h0);
        chk("idle_rdata", cpu_data_o, 32'h0);
        bus_released("idle");
    endtask

    // One core access: waits = BUSY cycles before ack (>= TO means no ack, timeout),
    // hold = cycles the other stall source stays active after completion.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [3:0] s, input int waits, input int hold,
                       input logic [5:0] sv, input logic [31:0] rdata);
        int          last;
        bit          tmo;
        logic [31:0] buf_v;
        tmo   = (waits >= TO);
        last  = tmo ? TO - 1 : waits;
        buf_v = (!w && !tmo) ? rdata : 32'h0;
        exp_ncyc++;

        @(negedge clk);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = a;
        cpu_data_i = d;
        cpu_we_i   = w;
        cpu_sel_i  = s;
        wb_ack_i   = 1'b0;
        stall_i    = 6'd0;
        #1;
        chk("req_stallreq", {31'h0, stallreq_o}, 32'h1);
        chk("req_rdata", cpu_data_o, 32'h0);
        bus_released("req");

        for (int b = 0; b <= last; b++) begin
            @(negedge clk);
            wb_ack_i  = (!tmo && b == waits);
            wb_data_i = wb_ack_i ? rdata : $urandom;
            stall_i   = (b == last && hold > 0) ? sv : 6'd0;
            #1;
            chk("busy_ctl", {28'h0, wb_cyc_o, wb_stb_o, wb_we_o, err_o}, {28'h0, 2'b11, w, 1'b0});
            chk("busy_addr", wb_addr_o, a);
            chk("busy_wdata", wb_data_o, d);
            chk("busy_sel", {28'h0, wb_sel_o}, {28'h0, s});
            chk("busy_stallreq", {31'h0, stallreq_o}, (b == last) ? 32'h0 : 32'h1);
            chk("busy_rdata", cpu_data_o, (b == last) ? buf_v : 32'h0);
        end
        pend_err = tmo;

        if (hold > 0) begin
            for (int h = 0; h <= hold; h++) begin
                @(negedge clk);
                cpu_ce_i  = 1'b0;
                wb_ack_i  = 1'($urandom_range(0, 1));
                wb_data_i = $urandom;
                stall_i   = (h < hold) ? sv : 6'd0;
                #1;
                chk("wait_stallreq", {31'h0, stallreq_o}, 32'h0);
                chk("wait_rdata", cpu_data_o, buf_v);
                bus_released("wait");
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        stall_i    = 6'd0;
        cpu_ce_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_data_i = 32'h0;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'h0;
        wb_data_i  = 32'h0;
        wb_ack_i   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stallreq", {31'h0, stallreq_o}, 32'h0);
        chk("rst_rdata", cpu_data_o, 32'h0);
        bus_released("rst");
        rst = 1'b0;

        // Load with one wait state, then store with three wait states.
        txn(32'h0000_0010, 32'h0, 1'b0, 4'b1111, 1, 0, 6'd0, 32'hDEAD_BEEF);
        idle_cycle();
        txn(32'h0000_0104, 32'h1234_5678, 1'b1, 4'b0011, 3, 0, 6'd0, 32'h5555_AAAA);
        idle_cycle();

        // Ack while another source stalls the pipeline.
        txn(32'h0000_0020, 32'h0, 1'b0, 4'b1111, 0, 3, 6'b000011, 32'hCAFE_0001);
        idle_cycle();
        idle_cycle();

        // Dead slave: timeout abort with err pulse.
        txn(32'h0000_0030, 32'h0, 1'b0, 4'b1111, 10, 0, 6'd0, 32'h0BAD_0BAD);
        idle_cycle();
        idle_cycle();

        // Reset asserted in the 2nd BUSY cycle, with an ack that must be discarded.
        exp_ncyc++;
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h40; cpu_we_i = 1'b1;
        cpu_data_i = 32'hFFFF_FFFF; cpu_sel_i = 4'hF; wb_ack_i = 1'b0;
        @(negedge clk);
        wb_ack_i = 1'b0;
        @(negedge clk);
        rst = 1'b1; wb_ack_i = 1'b1; wb_data_i = 32'h7777_7777;
        @(negedge clk);
        rst = 1'b0; cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
        #1;
        chk("rstmid_stallreq", {31'h0, stallreq_o}, 32'h0);
        chk("rstmid_rdata", cpu_data_o, 32'h0);
        bus_released("rstmid");
        idle_cycle();

        // Back-to-back loads: the request stays high straight after completion.
        txn(32'h0000_0000, 32'h0, 1'b0, 4'b1111, 0, 0, 6'd0, 32'h1111_0000);
        txn(32'h0000_0004, 32'h0, 1'b0, 4'b1111, 0, 0, 6'd0, 32'h2222_0004);
        idle_cycle();

        // Random mix of loads/stores, wait states, timeouts and downstream stalls.
        for (int i = 0; i < 40; i++) begin
            txn($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                6'($urandom_range(1, 63)), $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
        end
        idle_cycle();

        chk("wb_cycle_count", ncyc, exp_ncyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
